// File: rtl/omem_client_if.sv
// PE and router handshake bundle for omem_client.
// The slave modport is the client's view; the master modport is the PE/router side.
interface omem_client_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_first;
    logic        prev_valid;
    logic        prev_ready;
    logic [23:0] prev_pot;
    logic        prev_spike;
    logic        upd_valid;
    logic        upd_ready;
    logic [23:0] upd_pot;
    logic        upd_spike;
    logic        pkt_out_valid;
    logic        pkt_out_ready;
    logic [32:0] pkt_out_data;
    logic        pkt_in_valid;
    logic        pkt_in_ready;
    logic [32:0] pkt_in_data;

    modport slave (
        input  req_valid, req_first, prev_ready, upd_valid, upd_pot, upd_spike,
               pkt_out_ready, pkt_in_valid, pkt_in_data,
        output req_ready, prev_valid, prev_pot, prev_spike, upd_ready,
               pkt_out_valid, pkt_out_data, pkt_in_ready
    );

    modport master (
        output req_valid, req_first, prev_ready, upd_valid, upd_pot, upd_spike,
               pkt_out_ready, pkt_in_valid, pkt_in_data,
        input  req_ready, prev_valid, prev_pot, prev_spike, upd_ready,
               pkt_out_valid, pkt_out_data, pkt_in_ready
    );
endinterface

// File: rtl/omem_client.sv
// PE-side omem initiator: fetch previous neuron state, hand it to the PE, write back the update.
// Optional response timeout with retry is enabled by defining OMEM_CLIENT_TIMEOUT_EN.
module omem_client #(
    parameter logic [3:0] OMEM_ADDR      = 4'd12,
    parameter logic [3:0] NODE_ADDR      = 4'd3,
    parameter logic [2:0] PE_ID          = 3'd0,
    parameter int         NUM_NEURONS    = 441,
    parameter int         TIMEOUT_CYCLES = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    omem_client_if.slave  bus,
    output logic [8:0]    nrn_cnt,
    output logic          ts_done,
    output logic          err_unexp
`ifdef OMEM_CLIENT_TIMEOUT_EN
    ,
    output logic          err_timeout
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_REQ = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_PRESENT  = 3'd3,
        ST_WAIT_UPD = 3'd4,
        ST_SEND_WR  = 3'd5
    } state_t;

    if (NUM_NEURONS < 1 || NUM_NEURONS > 512 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("omem_client: NUM_NEURONS must be 1..512 and TIMEOUT_CYCLES >= 1");
    end

    function automatic logic [32:0] build_pkt(input logic rd, input logic [24:0] payload);
        return {OMEM_ADDR, PE_ID, rd, payload};
    endfunction

    state_t      state_r, next_state_s;
    logic        req_ready_r, prev_valid_r, upd_ready_r, pkt_out_valid_r, pkt_in_ready_r;
    logic [32:0] pkt_out_data_r;
    logic [23:0] prev_pot_r;
    logic        prev_spike_r;
    logic [8:0]  nrn_cnt_r;
    logic        ts_done_r;
    logic        err_unexp_r;

    logic req_xfer_s, prev_xfer_s, upd_xfer_s, pkt_out_xfer_s, pkt_in_xfer_s;
    logic rsp_ok_s, tmo_fire_s;

    assign req_xfer_s     = bus.req_valid     && req_ready_r;
    assign prev_xfer_s    = prev_valid_r      && bus.prev_ready;
    assign upd_xfer_s     = bus.upd_valid     && upd_ready_r;
    assign pkt_out_xfer_s = pkt_out_valid_r   && bus.pkt_out_ready;
    assign pkt_in_xfer_s  = bus.pkt_in_valid  && pkt_in_ready_r;
    // Only a read response addressed to this node and PE, seen while waiting for it, is accepted.
    assign rsp_ok_s = pkt_in_xfer_s && (state_r == ST_WAIT_RSP)
                    && (bus.pkt_in_data[32:29] == NODE_ADDR)
                    && (bus.pkt_in_data[28:25] == {PE_ID, 1'b1});

`ifdef OMEM_CLIENT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             err_timeout_r;

    assign tmo_fire_s = (state_r == ST_WAIT_RSP) && !rsp_ok_s
                      && (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

    // Response wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r     <= {TMO_W{1'b0}};
            err_timeout_r <= 1'b0;
        end else begin
            tmo_cnt_r     <= (state_r == ST_WAIT_RSP && !tmo_fire_s) ? tmo_cnt_r + TMO_W'(1)
                                                                     : {TMO_W{1'b0}};
            err_timeout_r <= err_timeout_r | tmo_fire_s;
        end
    end

    assign err_timeout = err_timeout_r;
`else
    assign tmo_fire_s = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_xfer_s) begin
                    next_state_s = bus.req_first ? ST_WAIT_UPD : ST_SEND_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SEND_REQ: begin
                if (pkt_out_xfer_s) next_state_s = ST_WAIT_RSP;
                else                next_state_s = ST_SEND_REQ;
            end
            ST_WAIT_RSP: begin
                if (rsp_ok_s)        next_state_s = ST_PRESENT;
                else if (tmo_fire_s) next_state_s = ST_SEND_REQ;
                else                 next_state_s = ST_WAIT_RSP;
            end
            ST_PRESENT: begin
                if (prev_xfer_s) next_state_s = ST_WAIT_UPD;
                else             next_state_s = ST_PRESENT;
            end
            ST_WAIT_UPD: begin
                if (upd_xfer_s) next_state_s = ST_SEND_WR;
                else            next_state_s = ST_WAIT_UPD;
            end
            ST_SEND_WR: begin
                if (pkt_out_xfer_s) next_state_s = ST_IDLE;
                else                next_state_s = ST_SEND_WR;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register and handshake outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            req_ready_r     <= 1'b0;
            prev_valid_r    <= 1'b0;
            upd_ready_r     <= 1'b0;
            pkt_out_valid_r <= 1'b0;
            pkt_in_ready_r  <= 1'b0;
        end else begin
            state_r         <= next_state_s;
            req_ready_r     <= (next_state_s == ST_IDLE);
            prev_valid_r    <= (next_state_s == ST_PRESENT);
            upd_ready_r     <= (next_state_s == ST_WAIT_UPD);
            pkt_out_valid_r <= (next_state_s == ST_SEND_REQ) || (next_state_s == ST_SEND_WR);
            pkt_in_ready_r  <= 1'b1;
        end
    end

    // Outgoing packet, fetched value and error capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_out_data_r <= 33'd0;
            prev_pot_r     <= 24'd0;
            prev_spike_r   <= 1'b0;
            err_unexp_r    <= 1'b0;
        end else begin
            if (req_xfer_s && !bus.req_first) begin
                pkt_out_data_r <= build_pkt(1'b1, {15'd0, nrn_cnt_r, 1'b0});
            end else if (upd_xfer_s) begin
                pkt_out_data_r <= build_pkt(1'b0, {bus.upd_pot, bus.upd_spike});
            end else begin
                pkt_out_data_r <= pkt_out_data_r;
            end
            if (rsp_ok_s) begin
                prev_pot_r   <= bus.pkt_in_data[24:1];
                prev_spike_r <= bus.pkt_in_data[0];
            end else begin
                prev_pot_r   <= prev_pot_r;
                prev_spike_r <= prev_spike_r;
            end
            err_unexp_r <= err_unexp_r | (pkt_in_xfer_s && !rsp_ok_s);
        end
    end

    // Neuron counter with end-of-timestep pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nrn_cnt_r <= 9'd0;
            ts_done_r <= 1'b0;
        end else if (state_r == ST_SEND_WR && pkt_out_xfer_s) begin
            if (nrn_cnt_r == 9'(NUM_NEURONS - 1)) begin
                nrn_cnt_r <= 9'd0;
                ts_done_r <= 1'b1;
            end else begin
                nrn_cnt_r <= nrn_cnt_r + 9'd1;
                ts_done_r <= 1'b0;
            end
        end else begin
            nrn_cnt_r <= nrn_cnt_r;
            ts_done_r <= 1'b0;
        end
    end

    assign bus.req_ready     = req_ready_r;
    assign bus.prev_valid    = prev_valid_r;
    assign bus.prev_pot      = prev_pot_r;
    assign bus.prev_spike    = prev_spike_r;
    assign bus.upd_ready     = upd_ready_r;
    assign bus.pkt_out_valid = pkt_out_valid_r;
    assign bus.pkt_out_data  = pkt_out_data_r;
    assign bus.pkt_in_ready  = pkt_in_ready_r;
    assign nrn_cnt           = nrn_cnt_r;
    assign ts_done           = ts_done_r;
    assign err_unexp         = err_unexp_r;

endmodule

// File: tb/tb_omem_client.sv
// Scoreboard bench for omem_client: expected packets/values queued at stimulus, checked on transfer.
module tb_omem_client;
    localparam logic [3:0] OMEM_ADDR   = 4'd12;
    localparam logic [3:0] NODE_ADDR   = 4'd3;
    localparam logic [2:0] PE_ID       = 3'd0;
    localparam int         NUM_NEURONS = 441;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    omem_client_if bus();
    logic [8:0] nrn_cnt;
    logic       ts_done;
    logic       err_unexp;
`ifdef OMEM_CLIENT_TIMEOUT_EN
    logic       err_timeout;
`endif

    omem_client #(
        .OMEM_ADDR(OMEM_ADDR), .NODE_ADDR(NODE_ADDR), .PE_ID(PE_ID), .NUM_NEURONS(NUM_NEURONS)
`ifdef OMEM_CLIENT_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .nrn_cnt(nrn_cnt), .ts_done(ts_done), .err_unexp(err_unexp)
`ifdef OMEM_CLIENT_TIMEOUT_EN
        , .err_timeout(err_timeout)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int ts_pulses = 0;
    int exp_cnt = 0;
    logic [32:0] pkt_q[$];
    logic [24:0] prev_q[$];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [32:0] mk_req(input int cnt);
        return {OMEM_ADDR, PE_ID, 1'b1, 24'(cnt), 1'b0};
    endfunction

    function automatic logic [32:0] mk_wr(input logic [23:0] pot, input logic spk);
        return {OMEM_ADDR, PE_ID, 1'b0, pot, spk};
    endfunction

    function automatic logic [32:0] mk_rsp(input logic [3:0] addr, input logic rd,
                                           input logic [23:0] pot, input logic spk);
        return {addr, PE_ID, rd, pot, spk};
    endfunction

    // Transfer monitor: compares every accepted packet and presented value against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pkt_out_valid && bus.pkt_out_ready) begin
                check_val("pkt_q_nonempty", 64'(pkt_q.size() != 0), 64'd1);
                if (pkt_q.size() != 0)
                    check_val("pkt_out_data", 64'(bus.pkt_out_data), 64'(pkt_q.pop_front()));
            end
            if (bus.prev_valid && bus.prev_ready) begin
                check_val("prev_q_nonempty", 64'(prev_q.size() != 0), 64'd1);
                if (prev_q.size() != 0)
                    check_val("prev_value", 64'({bus.prev_pot, bus.prev_spike}), 64'(prev_q.pop_front()));
            end
            if (ts_done) ts_pulses++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit first);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_first = first;
        if (!first) pkt_q.push_back(mk_req(exp_cnt));
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("req_handshake", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 1'b0;
        bus.req_first = 1'b0;
        if (!first) begin
            check_val("req_pkt_latency", 64'(bus.pkt_out_valid), 64'd1);
            check_val("req_pkt_data", 64'(bus.pkt_out_data), 64'(mk_req(exp_cnt)));
        end else begin
            check_val("upd_ready_latency", 64'(bus.upd_ready), 64'd1);
        end
    endtask

    task automatic wait_out_xfer(input string tag);
        int n = 0;
        @(negedge clk);
        while (!(bus.pkt_out_valid && bus.pkt_out_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 64'(bus.pkt_out_valid && bus.pkt_out_ready), 64'd1);
        tick();
    endtask

    task automatic do_upd(input logic [23:0] pot, input logic spk, input int hold);
        int n = 0;
        pkt_q.push_back(mk_wr(pot, spk));
        if (hold > 0) bus.pkt_out_ready = 1'b0;
        bus.upd_valid = 1'b1;
        bus.upd_pot   = pot;
        bus.upd_spike = spk;
        @(negedge clk);
        while (!bus.upd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("upd_handshake", 64'(bus.upd_ready), 64'd1);
        tick();
        bus.upd_valid = 1'b0;
        check_val("wr_pkt_latency", 64'(bus.pkt_out_valid), 64'd1);
        for (int c = 0; c < hold; c++) begin
            tick();
            check_val("bp_valid_hold", 64'(bus.pkt_out_valid), 64'd1);
            check_val("bp_data_stable", 64'(bus.pkt_out_data), 64'(mk_wr(pot, spk)));
            check_val("bp_nrn_cnt_hold", 64'(nrn_cnt), 64'(exp_cnt));
        end
        bus.pkt_out_ready = 1'b1;
        wait_out_xfer("wr_handshake");
        exp_cnt = (exp_cnt == NUM_NEURONS - 1) ? 0 : exp_cnt + 1;
        check_val("nrn_cnt", 64'(nrn_cnt), 64'(exp_cnt));
    endtask

    task automatic send_pkt(input logic [32:0] p);
        bus.pkt_in_valid = 1'b1;
        bus.pkt_in_data  = p;
        tick();
        bus.pkt_in_valid = 1'b0;
        bus.pkt_in_data  = 33'd0;
    endtask

    task automatic respond(input logic [23:0] pot, input logic spk);
        prev_q.push_back({pot, spk});
        send_pkt(mk_rsp(NODE_ADDR, 1'b1, pot, spk));
        check_val("prev_valid_latency", 64'(bus.prev_valid), 64'd1);
        check_val("prev_pot", 64'(bus.prev_pot), 64'(pot));
        check_val("prev_spike", 64'(bus.prev_spike), 64'(spk));
        tick();
        check_val("prev_consumed", 64'(bus.prev_valid), 64'd0);
        check_val("upd_ready_after_prev", 64'(bus.upd_ready), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_first = 1'b0; bus.prev_ready = 1'b1;
        bus.upd_valid = 1'b0; bus.upd_pot = 24'd0; bus.upd_spike = 1'b0;
        bus.pkt_out_ready = 1'b1; bus.pkt_in_valid = 1'b0; bus.pkt_in_data = 33'd0;

        // Reset state
        #12;
        check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check_val("rst_pkt_out_valid", 64'(bus.pkt_out_valid), 64'd0);
        check_val("rst_pkt_out_data", 64'(bus.pkt_out_data), 64'd0);
        check_val("rst_pkt_in_ready", 64'(bus.pkt_in_ready), 64'd0);
        check_val("rst_prev", 64'({bus.prev_valid, bus.prev_pot, bus.prev_spike}), 64'd0);
        check_val("rst_status", 64'({nrn_cnt, ts_done, err_unexp, bus.upd_ready}), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        check_val("idle_req_ready", 64'(bus.req_ready), 64'd1);
        check_val("idle_pkt_in_ready", 64'(bus.pkt_in_ready), 64'd1);
        check_val("ts_pulses_initial", 64'(ts_pulses), 64'd0);

        // First timestep: no fetch, full counter wrap
        for (int i = 0; i < NUM_NEURONS; i++) begin
            do_req(1'b1);
            do_upd(24'(i), 1'(i % 2), 0);
            if (i == NUM_NEURONS - 1) begin
                check_val("ts_done_pulse", 64'(ts_done), 64'd1);
                check_val("nrn_cnt_wrap", 64'(nrn_cnt), 64'd0);
                tick();
                check_val("ts_done_single", 64'(ts_done), 64'd0);
            end
        end
        check_val("ts_pulses_after_ts", 64'(ts_pulses), 64'd1);

        // Fetch path at nrn_cnt = 5
        for (int i = 0; i < 5; i++) begin
            do_req(1'b1);
            do_upd(24'(1000 + i), 1'b1, 0);
        end
        do_req(1'b0);
        check_val("req_payload_5", 64'(bus.pkt_out_data[24:0]), 64'd10);
        wait_out_xfer("req_xfer");
        respond(24'd77, 1'b1);
        do_upd(24'd80, 1'b0, 0);

        // Back-pressure on the write packet
        do_req(1'b1);
        do_upd(24'hABCDEF, 1'b1, 10);
        check_val("err_unexp_clean", 64'(err_unexp), 64'd0);

        // Stray packet in IDLE
        send_pkt(mk_rsp(NODE_ADDR, 1'b1, 24'd5, 1'b0));
        check_val("stray_idle_err", 64'(err_unexp), 64'd1);
        check_val("stray_idle_state", 64'(bus.req_ready), 64'd1);
        // Response colliding with the request transfer, then mismatched packets in WAIT_RSP
        do_req(1'b0);
        bus.pkt_in_valid = 1'b1;
        bus.pkt_in_data  = mk_rsp(NODE_ADDR, 1'b1, 24'd9, 1'b1);
        wait_out_xfer("req_xfer_collide");
        bus.pkt_in_valid = 1'b0;
        check_val("collide_dropped", 64'(bus.prev_valid), 64'd0);
        send_pkt(mk_rsp(NODE_ADDR, 1'b0, 24'd9, 1'b1));
        check_val("bad_opcode_dropped", 64'(bus.prev_valid), 64'd0);
        send_pkt(mk_rsp(4'd7, 1'b1, 24'd9, 1'b1));
        check_val("bad_addr_dropped", 64'(bus.prev_valid), 64'd0);
        check_val("err_unexp_sticky", 64'(err_unexp), 64'd1);
        respond(24'h123456, 1'b0);
        do_upd(24'd42, 1'b1, 0);
        check_val("err_unexp_still", 64'(err_unexp), 64'd1);

        // Reset while waiting for a response
        do_req(1'b0);
        wait_out_xfer("req_xfer_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mrst_pkt_out", 64'({bus.pkt_out_valid, bus.pkt_out_data}), 64'd0);
        check_val("mrst_ready", 64'({bus.req_ready, bus.upd_ready, bus.pkt_in_ready}), 64'd0);
        check_val("mrst_prev", 64'({bus.prev_valid, bus.prev_pot, bus.prev_spike}), 64'd0);
        check_val("mrst_status", 64'({nrn_cnt, ts_done, err_unexp}), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        exp_cnt = 0;
        do_req(1'b1);
        do_upd(24'd3, 1'b0, 0);

`ifdef OMEM_CLIENT_TIMEOUT_EN
        // Missing response: retry after the timeout, then a late response completes
        begin
            int n = 0;
            do_req(1'b0);
            wait_out_xfer("req_xfer_tmo");
            pkt_q.push_back(mk_req(exp_cnt));
            @(negedge clk);
            check_val("err_timeout_clear", 64'(err_timeout), 64'd0);
            while (!bus.pkt_out_valid && n < 50) begin
                n++;
                @(negedge clk);
            end
            check_val("tmo_cycles", 64'(n), 64'd8);
            check_val("err_timeout_set", 64'(err_timeout), 64'd1);
            check_val("retry_data", 64'(bus.pkt_out_data), 64'(mk_req(exp_cnt)));
            tick();
            wait_out_xfer("retry_xfer");
            respond(24'd555, 1'b1);
            do_upd(24'd556, 1'b0, 0);
            check_val("err_timeout_sticky", 64'(err_timeout), 64'd1);
        end
`endif

        tick();
        check_val("pkt_q_drained", 64'(pkt_q.size()), 64'd0);
        check_val("prev_q_drained", 64'(prev_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
